// File: rtl/eth_fcs_pad_inserter_32.sv
// Pads short Ethernet frames with zeros and appends the IEEE 802.3 CRC-32 FCS on a 32-bit stream.
// Latency: one register stage, so payload appears one cycle after it is accepted.
// Backpressure: m_* hold while m_axis_tready is low; input is held off during PAD/FCS and until the output tlast handshake.
module eth_fcs_pad_inserter_32 #(
    parameter int MIN_FRAME_BYTES = 60,
    parameter bit ENABLE_PAD      = 1'b1
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [31:0] s_axis_tdata,
    input  logic [3:0]  s_axis_tkeep,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tkeep,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        o_busy
);

    localparam logic [31:0] CRC_POLY  = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT  = 32'hFFFFFFFF;
    localparam logic [15:0] MIN_BYTES = 16'(MIN_FRAME_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PAD,
        ST_FCS
    } state_t;

    // Reflected CRC-32 update over one byte, LSB first as it goes on the wire.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_cur, input logic [7:0] dat);
        logic [31:0] c;
        c = crc_cur ^ {24'h0, dat};
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // CRC update over the enabled lanes of a beat, lane 0 first.
    function automatic logic [31:0] crc32_beat(input logic [31:0] crc_cur, input logic [31:0] dat,
                                               input logic [3:0] keep);
        logic [31:0] c;
        c = crc_cur;
        for (int i = 0; i < 4; i++) begin
            if (keep[i]) begin
                c = crc32_byte(c, dat[8*i +: 8]);
            end
        end
        return c;
    endfunction

    // Byte counter add that sticks at 0xFFFF instead of wrapping.
    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [2:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {14'h0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    function automatic logic [2:0] keep_bytes(input logic [3:0] keep);
        return {2'b00, keep[0]} + {2'b00, keep[1]} + {2'b00, keep[2]} + {2'b00, keep[3]};
    endfunction

    state_t      state;
    logic [31:0] crc;        // running CRC register (not yet final-XORed)
    logic [15:0] byte_cnt;   // bytes of data+pad emitted so far in this frame
    logic [1:0]  fcs_sent;   // FCS bytes already merged into the last data beat
    logic        bad;        // frame flagged bad on its input tlast beat

    logic        out_free;
    logic        s_fire;

    // Per-beat derived values for the input and for the PAD/FCS states.
    logic [3:0]  in_keep;
    logic [2:0]  in_nbytes;
    logic [31:0] in_data;
    logic [31:0] crc_in;
    logic [31:0] crc_in_pad;
    logic [31:0] crc_zero;
    logic [15:0] cnt_in;
    logic [15:0] cnt_plus4;
    logic        pad_needed;
    logic [31:0] fcs_in;
    logic [31:0] fcs_merge;
    logic [31:0] fcs_cur;
    logic [31:0] fcs_tail;
    logic [3:0]  fcs_tail_keep;

    // The output register can take a new beat when empty or being drained this cycle.
    assign out_free      = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = ((state == ST_IDLE) || (state == ST_DATA)) && out_free;
    assign s_fire        = s_axis_tvalid && s_axis_tready;

    // Normalise the input beat and precompute CRC, count and FCS views for the next state.
    always_comb begin
        in_keep = 4'hF;
        if (s_axis_tlast) begin
            // A zero keep on the last beat still carries one byte.
            in_keep = (s_axis_tkeep == 4'h0) ? 4'h1 : s_axis_tkeep;
        end
        in_nbytes = keep_bytes(in_keep);

        // Unused lanes are forced to zero so they double as pad bytes.
        in_data = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (in_keep[i]) begin
                in_data[8*i +: 8] = s_axis_tdata[8*i +: 8];
            end
        end

        crc_in     = crc32_beat(crc, in_data, in_keep);
        crc_in_pad = crc32_beat(crc, in_data, 4'hF);
        crc_zero   = crc32_beat(crc, 32'h0, 4'hF);
        cnt_in     = sat_add(byte_cnt, in_nbytes);
        cnt_plus4  = sat_add(byte_cnt, 3'd4);
        pad_needed = ENABLE_PAD && (cnt_in < MIN_BYTES);

        // Bad frames get the CRC without the final inversion, i.e. the bit-inverted FCS.
        fcs_in    = s_axis_tuser ? crc_in : ~crc_in;
        fcs_merge = in_data | (fcs_in << {in_nbytes, 3'b000});

        fcs_cur  = bad ? crc : ~crc;
        fcs_tail = fcs_cur >> {fcs_sent, 3'b000};
        case (fcs_sent)
            2'd0:    fcs_tail_keep = 4'hF;
            2'd1:    fcs_tail_keep = 4'h7;
            2'd2:    fcs_tail_keep = 4'h3;
            default: fcs_tail_keep = 4'h1;
        endcase
    end

    // Frame state machine with the registered output stage.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state         <= ST_IDLE;
            crc           <= CRC_INIT;
            byte_cnt      <= 16'h0;
            fcs_sent      <= 2'd0;
            bad           <= 1'b0;
            m_axis_tdata  <= 32'h0;
            m_axis_tkeep  <= 4'h0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            // Busy spans first accepted beat through the output tlast handshake.
            if (s_fire) begin
                o_busy <= 1'b1;
            end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                o_busy <= 1'b0;
            end

            if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            case (state)
                ST_IDLE, ST_DATA: begin
                    if (s_fire) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tkeep  <= 4'hF;
                        m_axis_tlast  <= 1'b0;
                        m_axis_tuser  <= 1'b0;
                        m_axis_tdata  <= in_data;
                        crc           <= crc_in;
                        byte_cnt      <= cnt_in;
                        if (!s_axis_tlast) begin
                            state <= ST_DATA;
                        end else begin
                            bad <= s_axis_tuser;
                            if (pad_needed) begin
                                // Last beat is zero-filled to a full word and counted as such.
                                crc      <= crc_in_pad;
                                byte_cnt <= cnt_plus4;
                                fcs_sent <= 2'd0;
                                state    <= (cnt_plus4 >= MIN_BYTES) ? ST_FCS : ST_PAD;
                            end else if (in_nbytes == 3'd4) begin
                                fcs_sent <= 2'd0;
                                state    <= ST_FCS;
                            end else begin
                                // Fill the free lanes of the last beat with the leading FCS bytes.
                                m_axis_tdata <= fcs_merge;
                                fcs_sent     <= 2'(3'd4 - in_nbytes);
                                state        <= ST_FCS;
                            end
                        end
                    end
                end

                ST_PAD: begin
                    if (out_free) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= 32'h0;
                        m_axis_tkeep  <= 4'hF;
                        m_axis_tlast  <= 1'b0;
                        m_axis_tuser  <= 1'b0;
                        crc           <= crc_zero;
                        byte_cnt      <= cnt_plus4;
                        if (cnt_plus4 >= MIN_BYTES) begin
                            state <= ST_FCS;
                        end
                    end
                end

                ST_FCS: begin
                    if (out_free) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= fcs_tail;
                        m_axis_tkeep  <= fcs_tail_keep;
                        m_axis_tlast  <= 1'b1;
                        m_axis_tuser  <= bad;
                        state         <= ST_IDLE;
                        crc           <= CRC_INIT;
                        byte_cnt      <= 16'h0;
                        fcs_sent      <= 2'd0;
                        bad           <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_fcs_pad_inserter_32.sv
// Bench for eth_fcs_pad_inserter_32: one padding instance (index 0) and one non-padding instance (index 1).
// Expected output beats are queued per instance when a frame is driven and compared on each output handshake.
// Output ready is either held high or randomised per cycle on instance 0.
`timescale 1ns/1ps
module tb_eth_fcs_pad_inserter_32;

    typedef struct packed {
        logic [31:0] dat;
        logic [3:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;

    logic [31:0] s_tdata  [2];
    logic [3:0]  s_tkeep  [2];
    logic        s_tvalid [2];
    logic        s_tready [2];
    logic        s_tlast  [2];
    logic        s_tuser  [2];
    logic [31:0] m_tdata  [2];
    logic [3:0]  m_tkeep  [2];
    logic        m_tvalid [2];
    logic        m_tready [2];
    logic        m_tlast  [2];
    logic        m_tuser  [2];
    logic        busy     [2];

    int          n_checks = 0;
    int          n_pass   = 0;
    beat_t       exp_q0[$];
    beat_t       exp_q1[$];
    logic [7:0]  frame_q[$];
    bit          sb_off     = 1'b0;
    bit          rand_ready = 1'b0;

    always #5 clk = ~clk;

    eth_fcs_pad_inserter_32 #(.MIN_FRAME_BYTES(60), .ENABLE_PAD(1'b1)) dut_pad (
        .iClk(clk), .iRst(rst),
        .s_axis_tdata(s_tdata[0]), .s_axis_tkeep(s_tkeep[0]), .s_axis_tvalid(s_tvalid[0]),
        .s_axis_tready(s_tready[0]), .s_axis_tlast(s_tlast[0]), .s_axis_tuser(s_tuser[0]),
        .m_axis_tdata(m_tdata[0]), .m_axis_tkeep(m_tkeep[0]), .m_axis_tvalid(m_tvalid[0]),
        .m_axis_tready(m_tready[0]), .m_axis_tlast(m_tlast[0]), .m_axis_tuser(m_tuser[0]),
        .o_busy(busy[0])
    );

    eth_fcs_pad_inserter_32 #(.MIN_FRAME_BYTES(60), .ENABLE_PAD(1'b0)) dut_nopad (
        .iClk(clk), .iRst(rst),
        .s_axis_tdata(s_tdata[1]), .s_axis_tkeep(s_tkeep[1]), .s_axis_tvalid(s_tvalid[1]),
        .s_axis_tready(s_tready[1]), .s_axis_tlast(s_tlast[1]), .s_axis_tuser(s_tuser[1]),
        .m_axis_tdata(m_tdata[1]), .m_axis_tkeep(m_tkeep[1]), .m_axis_tvalid(m_tvalid[1]),
        .m_axis_tready(m_tready[1]), .m_axis_tlast(m_tlast[1]), .m_axis_tuser(m_tuser[1]),
        .o_busy(busy[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int d, input beat_t b);
        if (d == 0) exp_q0.push_back(b);
        else        exp_q1.push_back(b);
    endtask

    // Reference: frame bytes, zero pad to 60 on the padding instance, CRC-32, FCS low byte first, cut into words.
    task automatic push_model(input int d, input bit bad_frame);
        logic [7:0]  ob[$];
        logic [31:0] c;
        logic [31:0] fcs;
        beat_t       b;
        int          n;
        ob = frame_q;
        if (d == 0) begin
            while (ob.size() < 60) ob.push_back(8'h00);
        end
        c = 32'hFFFFFFFF;
        foreach (ob[i]) begin
            c = c ^ {24'h0, ob[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        fcs = bad_frame ? c : ~c;
        for (int i = 0; i < 4; i++) ob.push_back(fcs[8*i +: 8]);
        n = ob.size();
        for (int i = 0; i < n; i += 4) begin
            b = '0;
            for (int j = 0; j < 4; j++) begin
                if (i + j < n) begin
                    b.dat[8*j +: 8] = ob[i+j];
                    b.keep[j]       = 1'b1;
                end
            end
            b.last = (i + 4 >= n);
            b.user = b.last && bad_frame;
            push_exp(d, b);
        end
    endtask

    task automatic send_beat(input int d, input logic [31:0] dat, input logic [3:0] keep,
                             input logic last, input logic user);
        int waited;
        waited      = 0;
        s_tdata[d]  = dat;
        s_tkeep[d]  = keep;
        s_tlast[d]  = last;
        s_tuser[d]  = user;
        s_tvalid[d] = 1'b1;
        @(negedge clk);
        while (!s_tready[d] && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 5000) check("s_tready_timeout", 64'(waited), 64'(0));
        @(posedge clk);
        #1;
        s_tvalid[d] = 1'b0;
    endtask

    task automatic send_frame(input int d, input bit bad_frame, input bit zero_keep, input bit use_model);
        int n;
        n = frame_q.size();
        if (use_model) push_model(d, bad_frame);
        for (int i = 0; i < n; i += 4) begin
            logic [31:0] dat;
            logic [3:0]  keep;
            logic        last;
            dat  = '0;
            keep = '0;
            for (int j = 0; j < 4; j++) begin
                if (i + j < n) begin
                    dat[8*j +: 8] = frame_q[i+j];
                    keep[j]       = 1'b1;
                end
            end
            last = (i + 4 >= n);
            if (last && zero_keep && keep == 4'h1) keep = 4'h0;
            send_beat(d, dat, keep, last, last ? bad_frame : 1'($urandom_range(0, 1)));
            if (i == 0) check("busy_after_first_beat", 64'(busy[d]), 64'(1));
        end
    endtask

    task automatic build_random(input int len);
        frame_q.delete();
        for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic wait_drain(input int budget);
        int c;
        c = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("drain_q0_left", 64'(exp_q0.size()), 64'(0));
        check("drain_q1_left", 64'(exp_q1.size()), 64'(0));
        @(posedge clk);
        #1;
        check("busy0_idle", 64'(busy[0]), 64'(0));
        check("busy1_idle", 64'(busy[1]), 64'(0));
    endtask

    // Scoreboard: every output handshake pops and compares one expected beat.
    always @(negedge clk) begin
        if (!rst && !sb_off) begin
            for (int d = 0; d < 2; d++) begin
                if (m_tvalid[d] && m_tready[d]) begin
                    beat_t got;
                    beat_t e;
                    got = {m_tdata[d], m_tkeep[d], m_tlast[d], m_tuser[d]};
                    if (d == 0) begin
                        check("dut0_beat_expected", 64'(exp_q0.size() != 0), 64'(1));
                        if (exp_q0.size() != 0) begin
                            e = exp_q0.pop_front();
                            check("dut0_beat", 64'(got), 64'(e));
                        end
                    end else begin
                        check("dut1_beat_expected", 64'(exp_q1.size() != 0), 64'(1));
                        if (exp_q1.size() != 0) begin
                            e = exp_q1.pop_front();
                            check("dut1_beat", 64'(got), 64'(e));
                        end
                    end
                end
            end
        end
    end

    // Downstream ready: always high, or a coin flip per cycle on instance 0.
    initial begin
        m_tready[0] = 1'b1;
        m_tready[1] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready[0] = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            m_tready[1] = 1'b1;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            s_tdata[d]  = '0;
            s_tkeep[d]  = '0;
            s_tvalid[d] = 1'b0;
            s_tlast[d]  = 1'b0;
            s_tuser[d]  = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_m_tvalid", 64'(m_tvalid[d]), 64'(0));
            check("rst_m_tdata",  64'(m_tdata[d]),  64'(0));
            check("rst_m_tkeep",  64'(m_tkeep[d]),  64'(0));
            check("rst_m_tlast",  64'(m_tlast[d]),  64'(0));
            check("rst_busy",     64'(busy[d]),     64'(0));
            check("rst_s_tready", 64'(s_tready[d]), 64'(1));
        end
        @(posedge clk);
        #1;

        // Known-answer vector on the non-padding instance.
        frame_q.delete();
        for (int i = 0; i < 9; i++) frame_q.push_back(8'h31 + 8'(i));
        push_exp(1, '{dat: 32'h34333231, keep: 4'hF, last: 1'b0, user: 1'b0});
        push_exp(1, '{dat: 32'h38373635, keep: 4'hF, last: 1'b0, user: 1'b0});
        push_exp(1, '{dat: 32'hF4392639, keep: 4'hF, last: 1'b0, user: 1'b0});
        push_exp(1, '{dat: 32'h000000CB, keep: 4'h1, last: 1'b1, user: 1'b0});
        send_frame(1, 1'b0, 1'b0, 1'b0);
        wait_drain(200);

        // Padding instance: short, boundary and bad frames.
        build_random(14);  send_frame(0, 1'b0, 1'b0, 1'b1);
        build_random(64);  send_frame(0, 1'b0, 1'b0, 1'b1);
        build_random(65);  send_frame(0, 1'b0, 1'b0, 1'b1);
        build_random(57);  send_frame(0, 1'b0, 1'b0, 1'b1);
        build_random(60);  send_frame(0, 1'b0, 1'b0, 1'b1);
        build_random(20);  send_frame(0, 1'b1, 1'b0, 1'b1);
        build_random(101); send_frame(0, 1'b1, 1'b0, 1'b1);
        build_random(5);   send_frame(0, 1'b0, 1'b1, 1'b1);
        build_random(1);   send_frame(0, 1'b0, 1'b0, 1'b1);
        wait_drain(500);

        // Non-padding instance: every last-beat fill level.
        build_random(64); send_frame(1, 1'b0, 1'b0, 1'b1);
        build_random(65); send_frame(1, 1'b0, 1'b0, 1'b1);
        build_random(6);  send_frame(1, 1'b1, 1'b0, 1'b1);
        build_random(7);  send_frame(1, 1'b0, 1'b0, 1'b1);
        build_random(4);  send_frame(1, 1'b0, 1'b0, 1'b1);
        build_random(9);  send_frame(1, 1'b0, 1'b1, 1'b1);
        wait_drain(500);

        // Random lengths with random downstream backpressure.
        rand_ready = 1'b1;
        for (int f = 0; f < 100; f++) begin
            build_random($urandom_range(1, 1500));
            send_frame(0, 1'($urandom_range(0, 7) == 0), 1'b0, 1'b1);
        end
        wait_drain(2000);
        rand_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of a frame drops it; the next frame must be intact.
        sb_off = 1'b1;
        build_random(40);
        for (int i = 0; i < 3; i++) begin
            send_beat(0, {frame_q[4*i+3], frame_q[4*i+2], frame_q[4*i+1], frame_q[4*i]}, 4'hF, 1'b0, 1'b0);
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_m_tvalid", 64'(m_tvalid[0]), 64'(0));
        check("midrst_m_tdata",  64'(m_tdata[0]),  64'(0));
        check("midrst_m_tkeep",  64'(m_tkeep[0]),  64'(0));
        check("midrst_m_tlast",  64'(m_tlast[0]),  64'(0));
        check("midrst_busy",     64'(busy[0]),     64'(0));
        @(posedge clk);
        #1;
        rst    = 1'b0;
        sb_off = 1'b0;
        build_random(30);
        send_frame(0, 1'b0, 1'b0, 1'b1);
        wait_drain(500);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
